// File: rtl/decrement_scheduler.sv
// Round-robin scheduler sharing one external combinational decrementor between
// NUM_CH countdown channels. Each channel holds a count; loads start/restart it,
// grants write back the decremented value and raise a one-cycle done pulse at zero.
module decrement_scheduler #(
  parameter  int unsigned N      = 4,
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ld_mask,
  input  logic [N-1:0]      ld_value,
  output logic [N-1:0]      dec_in,
  input  logic [N-1:0]      dec_out,
  output logic              grant_valid,
  output logic [CH_W-1:0]   grant_ch,
  output logic [NUM_CH-1:0] active,
  output logic [NUM_CH-1:0] done,
  output logic              busy
);

  logic [N-1:0]      cnt_q    [NUM_CH];
  logic [N-1:0]      cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] active_q, active_d;
  logic [NUM_CH-1:0] done_q,   done_d;
  logic [CH_W-1:0]   rr_q,     rr_d;

  logic              gnt_valid;
  logic [CH_W-1:0]   gnt_ch;
  logic              gnt_found;

  // Channel index base+off, wrapping at NUM_CH (NUM_CH need not be a power of two).
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return s[CH_W-1:0];
  endfunction

  // Grant search: first active channel from rr_q upward with wrap.
  always_comb begin
    gnt_valid = |active_q;
    gnt_ch    = '0;
    gnt_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!gnt_found && active_q[wrap_add(rr_q, i)]) begin
        gnt_found = 1'b1;
        gnt_ch    = wrap_add(rr_q, i);
      end
    end
  end

  // Next state: grant write-back first, then loads override per channel.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = '0;
    rr_d     = rr_q;
    if (gnt_valid) begin
      rr_d = wrap_add(gnt_ch, 1);
      if (!ld_mask[gnt_ch]) begin
        cnt_d[gnt_ch] = dec_out;
        if (dec_out == '0) begin
          active_d[gnt_ch] = 1'b0;
          done_d[gnt_ch]   = 1'b1;
        end
      end
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ld_mask[c]) begin
        cnt_d[c]    = ld_value;
        active_d[c] = (ld_value != '0);
        done_d[c]   = (ld_value == '0);
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
      active_q <= '0;
      done_q   <= '0;
      rr_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
      rr_q     <= rr_d;
    end
  end

  // Output drive: operand to the shared decrementor and status.
  always_comb begin
    grant_valid = gnt_valid;
    grant_ch    = gnt_ch;
    dec_in      = gnt_valid ? cnt_q[gnt_ch] : '0;
    active      = active_q;
    done        = done_q;
    busy        = |active_q;
  end

endmodule

// File: tb/tb_decrement_scheduler.sv
// Self-checking bench for decrement_scheduler: directed scenarios plus a
// randomized run compared against a behavioural model of the channel rules.
module tb_decrement_scheduler;

  localparam int unsigned N      = 4;
  localparam int unsigned NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NUM_CH-1:0] ld_mask = '0;
  logic [N-1:0]      ld_value = '0;
  logic [N-1:0]      dec_in;
  logic [N-1:0]      dec_out;
  logic              grant_valid;
  logic [1:0]        grant_ch;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] done;
  logic              busy;

  int errors = 0;
  int checks = 0;

  // Model state
  logic [N-1:0]      m_cnt [NUM_CH];
  logic [NUM_CH-1:0] m_active;
  logic [NUM_CH-1:0] m_done;
  int unsigned       m_rr;

  decrement_scheduler #(.N(N), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .ld_mask(ld_mask), .ld_value(ld_value),
    .dec_in(dec_in), .dec_out(dec_out), .grant_valid(grant_valid),
    .grant_ch(grant_ch), .active(active), .done(done), .busy(busy)
  );

  // Attached decrementor
  assign dec_out = dec_in - 4'd1;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  function automatic void m_reset();
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = '0;
    m_active = '0;
    m_done   = '0;
    m_rr     = 0;
  endfunction

  function automatic void m_grant(output bit v, output int unsigned ch);
    v  = 0;
    ch = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!v && m_active[(m_rr + k) % NUM_CH]) begin
        v  = 1;
        ch = (m_rr + k) % NUM_CH;
      end
    end
  endfunction

  function automatic void m_edge(input logic [NUM_CH-1:0] mask, input logic [N-1:0] val);
    bit          v;
    int unsigned ch;
    logic [N-1:0] r;
    logic [NUM_CH-1:0] nd;
    nd = '0;
    m_grant(v, ch);
    if (v) begin
      r = m_cnt[ch] - 4'd1;
      if (!mask[ch]) begin
        m_cnt[ch] = r;
        if (r == 0) begin
          m_active[ch] = 0;
          nd[ch] = 1;
        end
      end
      m_rr = (ch + 1) % NUM_CH;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        m_cnt[c]    = val;
        m_active[c] = (val != 0);
        nd[c]       = (val == 0);
      end
    end
    m_done = nd;
  endfunction

  // One clock: present inputs, advance DUT and model, return at posedge+1.
  task automatic step(input logic [NUM_CH-1:0] mask, input logic [N-1:0] val);
    ld_mask  = mask;
    ld_value = val;
    @(posedge clk);
    m_edge(mask, val);
    #1;
    ld_mask  = '0;
    ld_value = '0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    m_reset();
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid: got %b want 0", grant_valid); end
    checks++; if (dec_in !== 4'd0) begin errors++; $display("FAIL reset_dec_in: got %0d want 0", dec_in); end
    checks++; if (grant_ch !== 2'd0) begin errors++; $display("FAIL reset_grant_ch: got %0d want 0", grant_ch); end
    checks++; if (active !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b want 0000", active); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step('0, '0);
      checks++;
      if (grant_valid !== 1'b0 || dec_in !== 4'd0 || busy !== 1'b0 || done !== 4'b0000) begin
        errors++;
        $display("FAIL idle[%0d]: got gv=%b dec_in=%0d busy=%b done=%b want 0/0/0/0000",
                 i, grant_valid, dec_in, busy, done);
      end
    end
  endtask

  task automatic test_single;
    step(4'b0010, 4'd3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (grant_valid !== 1'b1 || grant_ch !== 2'd1 || dec_in !== 4'(3 - i) || done !== 4'b0000) begin
        errors++;
        $display("FAIL single_grant[%0d]: got gv=%b ch=%0d dec_in=%0d done=%b want 1/1/%0d/0000",
                 i, grant_valid, grant_ch, dec_in, done, 3 - i);
      end
      step('0, '0);
    end
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL single_done: got %b want 0010", done); end
    checks++; if (active !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got active=%b busy=%b want 0000/0", active, busy); end
    step('0, '0);
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_done_clear: got %b want 0000", done); end
  endtask

  task automatic test_round_robin;
    int seq [6] = '{0, 2, 3, 0, 2, 3};
    logic [NUM_CH-1:0] dexp [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100};
    // Bring the pointer back to 0: ch3 granted once from rr_ptr=2.
    step(4'b1000, 4'd1);
    step('0, '0);
    step('0, '0);
    step(4'b1101, 4'd2);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (grant_valid !== 1'b1 || grant_ch !== 2'(seq[i]) || done !== dexp[i]) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got gv=%b ch=%0d done=%b want 1/%0d/%b",
                 i, grant_valid, grant_ch, done, seq[i], dexp[i]);
      end
      step('0, '0);
    end
    checks++; if (done !== 4'b1000) begin errors++; $display("FAIL rr_done3: got %b want 1000", done); end
    step('0, '0);
    checks++; if (done !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rr_end: got done=%b busy=%b want 0000/0", done, busy); end
  endtask

  task automatic test_zero_load;
    step(4'b0100, 4'd0);
    checks++;
    if (grant_valid !== 1'b0 || done !== 4'b0100 || active !== 4'b0000) begin
      errors++;
      $display("FAIL zero_load: got gv=%b done=%b active=%b want 0/0100/0000", grant_valid, done, active);
    end
    step('0, '0);
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL zero_load_clear: got %b want 0000", done); end
  endtask

  task automatic test_reload_collision;
    step(4'b0001, 4'd5);
    for (int i = 0; i < 2; i++) begin
      checks++; if (dec_in !== 4'(5 - i)) begin errors++; $display("FAIL coll_pre[%0d]: got %0d want %0d", i, dec_in, 5 - i); end
      step('0, '0);
    end
    checks++; if (dec_in !== 4'd3) begin errors++; $display("FAIL coll_third: got %0d want 3", dec_in); end
    step(4'b0001, 4'd4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (grant_ch !== 2'd0 || dec_in !== 4'(4 - i) || done !== 4'b0000) begin
        errors++;
        $display("FAIL coll_post[%0d]: got ch=%0d dec_in=%0d done=%b want 0/%0d/0000", i, grant_ch, dec_in, done, 4 - i);
      end
      step('0, '0);
    end
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL coll_done: got %b want 0001", done); end
    step('0, '0);
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL coll_done_clear: got %b want 0000", done); end
  endtask

  task automatic test_async_reset;
    step(4'b0001, 4'd7);
    step(4'b0010, 4'd5);
    step(4'b0100, 4'd2);
    checks++; if (busy !== 1'b1 || active !== 4'b0111) begin errors++; $display("FAIL ar_pre: got busy=%b active=%b want 1/0111", busy, active); end
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    checks++;
    if (active !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_assert: got active=%b done=%b busy=%b gv=%b want 0000/0000/0/0", active, done, busy, grant_valid);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step('0, '0);
      checks++;
      if (done !== 4'b0000 || grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL ar_after[%0d]: got done=%b gv=%b want 0000/0", i, done, grant_valid);
      end
    end
  endtask

  task automatic test_random;
    bit          ev;
    int unsigned ech;
    logic [NUM_CH-1:0] mask;
    logic [N-1:0]      val;
    for (int i = 0; i < 400; i++) begin
      m_grant(ev, ech);
      checks++;
      if (grant_valid !== logic'(ev) || grant_ch !== 2'(ech) ||
          dec_in !== (ev ? m_cnt[ech] : 4'd0) || active !== m_active ||
          done !== m_done || busy !== (|m_active)) begin
        errors++;
        $display("FAIL rand[%0d]: got gv=%b ch=%0d dec_in=%0d act=%b done=%b busy=%b want %b/%0d/%0d/%b/%b/%b",
                 i, grant_valid, grant_ch, dec_in, active, done, busy,
                 ev, ech, ev ? m_cnt[ech] : 4'd0, m_active, m_done, |m_active);
      end
      mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      val  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
      step(mask, val);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_zero_load();
    test_reload_collision();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decrement_scheduler.md
Name: decrement_scheduler

Overview:
Round-robin scheduler that time-shares one combinational N-bit decrementor between NUM_CH countdown channels. It holds one count register per channel and loads channels on request. Each cycle it grants the shared decrementor to one active channel, writes the result back, and signals completion when a channel reaches zero. It sits beside the arithmetic decrementor in the arithmetic block and drives that decrementor's input and consumes its output.

Parameters:
N, 4, count width (must match the attached decrementor)
NUM_CH, 4, number of countdown channels (>=2)
CH_W, clog2(NUM_CH), channel index width (derived; not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ld_mask  in  NUM_CH  per-channel load strobe; several bits may be set in one cycle
ld_value  in  N  value loaded into every channel selected by ld_mask
dec_in  out  N  operand to shared decrementor; cnt[grant_ch] when grant_valid, else 0
dec_out  in  N  decrementor result (combinational, dec_in-1 mod 2^N)
grant_valid  out  1  a channel owns the decrementor this cycle
grant_ch  out  CH_W  granted channel index; 0 when grant_valid=0
active  out  NUM_CH  channel counting (registered)
done  out  NUM_CH  one-cycle completion pulse per channel (registered)
busy  out  1  OR of active

Behaviour:
- Reset (rst_n low, immediate, asynchronous): all cnt=0, active=0, done=0, rr_ptr=0. The combinational outputs dec_in, grant_valid, grant_ch and busy therefore read 0.
- Grant (combinational): grant_ch is the first channel with active=1, searching from rr_ptr upward with wrap at NUM_CH. grant_valid=|active. dec_in=cnt[grant_ch] when grant_valid=1.
- Per rising edge, when grant_valid=1 and ld_mask[grant_ch]=0:
  - cnt[grant_ch] <= dec_out.
  - If dec_out==0: active[grant_ch] <= 0 and done[grant_ch] <= 1 for exactly the next cycle.
  - rr_ptr <= (grant_ch+1) mod NUM_CH.
- Per rising edge, when grant_valid=0: rr_ptr holds.
- Load, for each channel c with ld_mask[c]=1:
  - ld_value!=0: cnt[c] <= ld_value, active[c] <= 1.
  - ld_value==0: cnt[c] <= 0, active[c] <= 0, done[c] <= 1 next cycle. The channel is never granted.
- Load collision: a load takes priority over the write-back for the same channel in the same cycle. The decrement result is discarded, no done pulse is generated from it, and rr_ptr still advances past grant_ch.
- Loading a channel that is already active restarts it with the new value. No error is raised.
- done bits not set by a grant or a zero-load this cycle return to 0. Several done bits may be high in the same cycle.
- Wrap-around: an active channel always holds a nonzero count, so the decrementor never sees 0 from this block. The 0 -> 2^N-1 wrap is never written back.
- Latency: a single active channel loaded with V is granted on the V consecutive cycles after the load edge. done pulses in the cycle after the V-th grant. With k active channels, each channel is granted once every k cycles (fairness bound k-1 idle cycles).
- An async reset asserted mid-count clears everything. After release no stale done pulse appears, and the block idles until the next load.

Test Plan:
- Reset and idle: drive rst_n=0 between clock edges -> all outputs 0 immediately. Release with no load -> dec_in=0, grant_valid=0, busy=0 for 10 cycles.
- Single channel: ld_mask=4'b0010, ld_value=3 -> next 3 cycles grant_ch=1 with dec_in=3,2,1. Following cycle done=4'b0010 for exactly one cycle. active[1]=0, busy=0.
- Round robin: from rr_ptr=0, ld_mask=4'b1101, ld_value=2 -> grant_ch sequence 0,2,3,0,2,3. done[0], done[2], done[3] each pulse once, in the cycles after the 4th, 5th and 6th grants respectively.
- Zero load: ld_mask=4'b0100, ld_value=0 -> no grant. done=4'b0100 next cycle. active stays 0.
- Reload collision: ch0 loaded 5. On the 3rd grant of ch0 (dec_in=3), assert ld_mask=4'b0001, ld_value=4 -> cnt[0]=4 after the edge, not 2. Four more grants with dec_in=4,3,2,1, then a single done[0].
- Async reset mid-operation: three channels active with counts 7, 5, 2. Pull rst_n low mid-cycle -> active, done and busy go 0 immediately. After release, no done pulses and grant_valid=0 until the next load.
